// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared types and constants for the direct-mapped cache.
//   cache_state_e : controller FSM states (IDLE / RD_MISS / WR_THRU)
//   calc_tag_w()  : tag width from address and index widths
//   STAT_W        : width of the optional hit/miss statistics counters
package dm_cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } cache_state_e;

  localparam int STAT_W = 32;

  function automatic int calc_tag_w(input int addr_w, input int index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// dm_cache_array: data + tag + valid storage for the direct-mapped cache.
//   clk, rst_n          : clock, async active-low reset (valid bits only)
//   rd_idx              : combinational read port index
//   rd_data/rd_tag/rd_valid : contents of line rd_idx
//   wr_en/wr_idx/wr_data/wr_tag : synchronous write; also sets the valid bit
//   clr_all             : bulk clear of every valid bit (wins over wr_en)
module dm_cache_array #(
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 5,
  parameter int INDEX_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [DATA_W-1:0]  rd_data,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               clr_all
);

  localparam int LINES = 2**INDEX_W;

  logic [DATA_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  // Data and tags are never reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_data;
      tag_mem[wr_idx]  <= wr_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (clr_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  assign rd_data  = data_mem[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, no-write-allocate cache.
// Read hits complete in one cycle; read misses fill from backing memory over
// a level req / single-cycle ack handshake; every write goes to memory.
//   clk, rst_n                     : clock, async active-low reset
//   cpu_rd, cpu_wr, cpu_addr, cpu_wdata, flush : CPU requests (wr beats rd)
//   cpu_ready, cpu_valid, cpu_rdata : CPU handshake / read data
//   mem_rd, mem_wr, mem_addr, mem_wdata : backing-memory request (registered)
//   mem_rdata, mem_ack             : backing-memory response
//   hit_cnt, miss_cnt              : saturating statistics, only when the
//                                    DM_CACHE_STATS_EN macro is defined
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              flush,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt
`endif
);

  localparam int TAG_W = calc_tag_w(ADDR_W, INDEX_W);

  cache_state_e state;

  logic [INDEX_W-1:0] cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [DATA_W-1:0]  arr_rd_data;
  logic [TAG_W-1:0]   arr_rd_tag;
  logic               arr_rd_valid;
  logic               arr_wr_en;
  logic [INDEX_W-1:0] arr_wr_idx;
  logic [DATA_W-1:0]  arr_wr_data;
  logic [TAG_W-1:0]   arr_wr_tag;
  logic               arr_clr;
  logic               hit;
  logic               accept;

  assign cpu_idx   = cpu_addr[INDEX_W-1:0];
  assign cpu_tag   = cpu_addr[ADDR_W-1:INDEX_W];
  assign hit       = arr_rd_valid && (arr_rd_tag == cpu_tag);
  assign cpu_ready = (state == IDLE);
  // A request only counts when flush is not dropping it.
  assign accept    = cpu_ready && !flush && (cpu_rd || cpu_wr);
  assign arr_clr   = cpu_ready && flush;

  dm_cache_array #(
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (cpu_idx),
    .rd_data  (arr_rd_data),
    .rd_tag   (arr_rd_tag),
    .rd_valid (arr_rd_valid),
    .wr_en    (arr_wr_en),
    .wr_idx   (arr_wr_idx),
    .wr_data  (arr_wr_data),
    .wr_tag   (arr_wr_tag),
    .clr_all  (arr_clr)
  );

  // Single array write port shared by write hits (IDLE) and fills (RD_MISS).
  // A write hit rewrites the same tag and valid bit, so only data changes.
  always_comb begin
    arr_wr_en   = 1'b0;
    arr_wr_idx  = cpu_idx;
    arr_wr_data = cpu_wdata;
    arr_wr_tag  = cpu_tag;
    if (state == IDLE && !flush && cpu_wr && hit) begin
      arr_wr_en = 1'b1;
    end else if (state == RD_MISS && mem_ack) begin
      arr_wr_en   = 1'b1;
      arr_wr_idx  = mem_addr[INDEX_W-1:0];
      arr_wr_data = mem_rdata;
      arr_wr_tag  = mem_addr[ADDR_W-1:INDEX_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpu_valid <= 1'b0;
      cpu_rdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            // Valid bits are cleared by the array; requests are dropped.
          end else if (cpu_wr) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_wr    <= 1'b1;
            state     <= WR_THRU;
          end else if (cpu_rd) begin
            if (hit) begin
              cpu_rdata <= arr_rd_data;
              cpu_valid <= 1'b1;
            end else begin
              mem_addr <= cpu_addr;
              mem_rd   <= 1'b1;
              state    <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            cpu_rdata <= mem_rdata;
            cpu_valid <= 1'b1;
            mem_rd    <= 1'b0;
            state     <= IDLE;
          end
        end
        WR_THRU: begin
          if (mem_ack) begin
            cpu_valid <= 1'b1;
            mem_wr    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef DM_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + STAT_W'(1);
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + STAT_W'(1);
      end
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
module tb_dm_cache_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       flush;
  logic       cpu_ready;
  logic       cpu_valid;
  logic [7:0] cpu_rdata;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  dm_cache_ctrl #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .INDEX_W (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .flush     (flush),
    .cpu_ready (cpu_ready),
    .cpu_valid (cpu_valid),
    .cpu_rdata (cpu_rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DM_CACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: one entry per expected cpu_valid pulse, carrying cpu_rdata.
  typedef struct {
    bit         is_rd;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cpu_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check(e.is_rd ? "rd_data" : "wr_rdata_hold", {24'd0, cpu_rdata}, {24'd0, e.data});
        end
      end
    end
  end

  // Backing memory: acks after mem_wait extra cycles, checks request hold.
  logic [7:0] mem [256];
  int mem_wait = 0;
  int rd_reqs  = 0;
  int wr_reqs  = 0;

  initial begin
    bit         is_wr;
    logic [7:0] a;
    logic [7:0] wd;
    int         k;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_rd || mem_wr)) begin
        is_wr = mem_wr;
        a     = mem_addr;
        wd    = mem_wdata;
        if (is_wr) wr_reqs++; else rd_reqs++;
        k = 0;
        while (k < mem_wait) begin
          @(negedge clk);
          if (!rst_n) break;
          check("req_hold", {is_wr ? mem_wr : mem_rd, mem_addr}, {1'b1, a});
          if (is_wr) check("wdata_hold", {24'd0, mem_wdata}, {24'd0, wd});
          k++;
        end
        if (rst_n) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[a];
          if (is_wr) mem[a] = wd;
          @(negedge clk);
          mem_ack   = 1'b0;
        end
      end
    end
  end

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input bit miss, input int w);
    int r0 = rd_reqs;
    int w0 = wr_reqs;
    int lat = 1;
    mem_wait = w;
    sb.push_back('{1'b1, exp});
    check("ready_before_rd", {31'd0, cpu_ready}, 32'd1);
    cpu_rd = 1'b1;
    cpu_addr = a;
    @(posedge clk);
    #1 cpu_rd = 1'b0;
    @(negedge clk);
    check("ready_after_rd", {31'd0, cpu_ready}, {31'd0, !miss});
    while (!cpu_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("rd_done", {31'd0, cpu_valid}, 32'd1);
    check("rd_latency", lat, miss ? 2 + w : 1);
    check("rd_mem_reqs", rd_reqs - r0, miss ? 1 : 0);
    check("rd_no_mem_wr", wr_reqs - w0, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic [7:0] hold_rdata,
                          input bit also_rd, input int w);
    int w0 = wr_reqs;
    int r0 = rd_reqs;
    int lat = 1;
    mem_wait = w;
    sb.push_back('{1'b0, hold_rdata});
    cpu_wr = 1'b1;
    cpu_rd = also_rd;
    cpu_addr = a;
    cpu_wdata = d;
    @(posedge clk);
    #1 begin cpu_wr = 1'b0; cpu_rd = 1'b0; end
    @(negedge clk);
    check("wr_mem_req", {mem_wr, mem_addr, mem_wdata}, {1'b1, a, d});
    while (!cpu_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("wr_done", {31'd0, cpu_valid}, 32'd1);
    check("wr_latency", lat, 2 + w);
    check("wr_mem_reqs", wr_reqs - w0, 1);
    check("wr_no_mem_rd", rd_reqs - r0, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h15] = 8'hA5;
    mem[8'h0D] = 8'h11;
    mem[8'h2A] = 8'h5A;
    rst_n = 1'b0;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    flush = 1'b0;
    #12;
    check("reset_outputs", {cpu_ready, cpu_valid, mem_rd, mem_wr}, 4'b1000);
    check("reset_data", {cpu_rdata, mem_addr, mem_wdata}, 24'd0);
`ifdef DM_CACHE_STATS_EN
    check("reset_hit_cnt", hit_cnt, 0);
    check("reset_miss_cnt", miss_cnt, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_read(8'h15, 8'hA5, 1, 3);           // cold miss, 3 wait cycles
    do_read(8'h15, 8'hA5, 0, 0);           // hit
    do_write(8'h15, 8'h3C, 8'hA5, 1, 1);   // write hit, rd also high
    do_read(8'h15, 8'h3C, 0, 0);           // hit sees new data
    do_write(8'h2A, 8'h77, 8'h3C, 0, 0);   // write miss, no allocate
    do_read(8'h2A, 8'h77, 1, 0);           // still a miss
    do_read(8'h0D, 8'h11, 1, 2);           // conflict on index 5
    do_read(8'h15, 8'h3C, 1, 0);           // evicted: refetch

    // Flush with a read in the same cycle: read dropped, no valid.
    r0 = rd_reqs;
    flush = 1'b1;
    cpu_rd = 1'b1;
    cpu_addr = 8'h0D;
    @(posedge clk);
    #1 begin flush = 1'b0; cpu_rd = 1'b0; end
    repeat (2) begin
      @(negedge clk);
      check("flush_no_valid", {31'd0, cpu_valid}, 32'd0);
      check("flush_ready", {31'd0, cpu_ready}, 32'd1);
    end
    check("flush_no_mem_rd", rd_reqs - r0, 0);
    @(posedge clk);
    #1;
    do_read(8'h0D, 8'h11, 1, 0);           // miss after flush
    do_read(8'h0D, 8'h11, 0, 0);           // hit again
`ifdef DM_CACHE_STATS_EN
    check("hit_cnt", hit_cnt, 4);
    check("miss_cnt", miss_cnt, 6);
`endif

    // Reset in the middle of a read miss.
    mem_wait = 8;
    cpu_rd = 1'b1;
    cpu_addr = 8'h2A;
    @(posedge clk);
    #1 cpu_rd = 1'b0;
    @(posedge clk);
    #1;
    check("miss_pending", {mem_rd, cpu_ready}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {cpu_ready, cpu_valid, mem_rd, mem_wr}, 4'b1000);
`ifdef DM_CACHE_STATS_EN
    check("rst_mid_miss_cnt", miss_cnt, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_read(8'h0D, 8'h11, 1, 0);           // valid bits cleared by reset
`ifdef DM_CACHE_STATS_EN
    check("final_miss_cnt", miss_cnt, 1);
`endif

    repeat (2) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
